neuron_seq_ctrl: RTL and testbench
==================================

Name: neuron_seq_ctrl

Overview:
Sequencer for one acc_encapsule_IF neuron. It runs a full evaluation per start pulse: load the initial membrane voltage, stream N operand sets from an upstream valid/ready source into the neuron, wait out the neuron latency, pulse output_en, then capture the neuron results. It also keeps a saturating spike counter. It sits between the layer scheduler / operand fetch logic and the neuron instance.

Parameters:
CNT_W, 8, width of num_pairs and the internal pair counter (max 2^CNT_W-1 pairs per run)
NEURON_LAT, 1, cycles from last n_input_valid to n_output_en (range 1..15)
OUT_LAT, 1, cycles from the edge ending n_output_en to the capture edge (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  run request; accepted only in IDLE
abort  in  1  synchronous cancel; return to IDLE, no done
mode  in  1  0 = MAC (arithm=0), 1 = diff-accumulate (arithm=1); latched at start
num_pairs  in  CNT_W  operand sets per run; latched at start
init_vol  in  16  initial membrane voltage; latched at start
busy  out  1  high from accepted start until done or abort
done  out  1  one-cycle pulse, coincident with res_valid
s_valid  in  1  upstream operand valid
s_ready  out  1  controller accepts an operand set
s_act  in  8  signed activation
s_wgt  in  8  signed weight
s_diff  in  16  signed membrane-voltage difference (mode 1 only)
n_activation  out  8  to neuron activation
n_weight  out  8  to neuron weight
n_input_mem_vol  out  16  to neuron input_mem_vol
n_mem_vol_diff  out  16  to neuron mem_vol_diff_2_be_add
n_load_en  out  1  to neuron load_en
n_arithm  out  1  to neuron arithm
n_input_valid  out  1  to neuron input_valid
n_output_en  out  1  to neuron output_en
n_out_mem_vol  in  16  from neuron out_mem_vol
n_post_mem_vol_diff  in  16  from neuron post_mem_vol_diff
n_spike_out  in  1  from neuron spike_out
res_valid  out  1  result registers updated this cycle (one-cycle pulse)
res_mem_vol  out  16  captured out_mem_vol; held until next capture
res_vol_diff  out  16  captured post_mem_vol_diff; held until next capture
res_spike  out  1  captured spike_out; held until next capture
spike_cnt  out  16  saturating count of captured spikes
cnt_clr  in  1  synchronous clear of spike_cnt

Behaviour:
- Reset: every output is 0, state is IDLE, counters are 0. Reset mid-run cancels the run with no done. All outputs are registered except s_ready.
- FSM states: IDLE, LOAD, FEED, DRAIN, OUTEN, WAITOUT, CAPT.
- IDLE: when start=1, latch mode/num_pairs/init_vol and go to LOAD. busy=1 from the next cycle.
- LOAD: for one cycle, n_load_en=1 and n_input_mem_vol=init_vol. n_arithm=mode for the whole busy period. Next state is FEED, or DRAIN if num_pairs=0.
- FEED: s_ready = (state==FEED) && (cnt<num_pairs) && !abort.
  - An accept (s_valid && s_ready) in cycle t drives n_input_valid=1 in cycle t+1, with n_activation=s_act and n_weight=s_wgt.
  - n_mem_vol_diff = s_diff in mode 1, and 0 in mode 0.
  - Back-to-back accepts give consecutive n_input_valid cycles. Gaps in s_valid give gaps in n_input_valid.
  - Operand outputs hold their last value when n_input_valid=0.
  - The accept that makes cnt==num_pairs moves the FSM to DRAIN.
- DRAIN: n_output_en is asserted exactly NEURON_LAT cycles after the last n_input_valid cycle. With num_pairs=0, NEURON_LAT cycles after the n_load_en cycle.
- OUTEN: n_output_en=1 for exactly one cycle.
- WAITOUT: wait OUT_LAT-1 cycles.
- CAPT: sample n_out_mem_vol, n_post_mem_vol_diff and n_spike_out into res_* on the edge OUT_LAT cycles after the edge that ended n_output_en. In the following cycle res_valid=1 and done=1, and the FSM returns to IDLE (busy=0 in that cycle). A start in the done cycle is ignored; start is honoured from the next IDLE cycle.
- spike_cnt increments by 1 on each capture with spike=1 and saturates at 0xFFFF. cnt_clr has priority over an increment in the same cycle.
- abort has priority over every other input in any busy state:
  - The next cycle is IDLE, busy=0, all neuron strobes are 0, s_ready=0 in the abort cycle.
  - No done and no res update. res_* and spike_cnt are unchanged.
- start while busy: ignored. The latched fields do not change mid-run.

Test Plan:
- MAC run: init_vol=63, mode=0, num_pairs=4, s_valid held high with (5,8), (9,-4), (-7,10), (-5,-3) -> one n_load_en cycle with 63; four consecutive n_input_valid cycles with exactly those operands; n_arithm=0 and n_mem_vol_diff=0 throughout; n_output_en 1 cycle after the last input_valid; done 2 cycles after n_output_en; res_* equals the neuron outputs at capture.
- Accumulate run: mode=1, num_pairs=2, operands (40,1,43) and (-4,-3,120) with s_valid low for 1 cycle between them -> n_arithm=1; n_mem_vol_diff shows 43 then 120; n_input_valid has a 1-cycle gap; done exactly once.
- num_pairs=0, init_vol=-5 -> load, no s_ready, no n_input_valid, n_output_en 1 cycle after n_load_en, done follows.
- Abort in the 2nd FEED cycle of a 4-pair run -> s_ready=0 in the abort cycle, IDLE next cycle, no n_output_en, no done, res_* unchanged. A following start runs normally.
- rst_n low for 1 cycle mid-DRAIN -> all outputs 0 immediately (asynchronously); no done after release.
- Force n_spike_out=1 over 3 runs, then cnt_clr in the same cycle as a 4th capture -> spike_cnt goes 1, 2, 3, then 0. Preload via force to 0xFFFF and run one more spiking run -> spike_cnt stays 0xFFFF.

Source files
------------

// File: rtl/neuron_seq_ctrl.sv
// Sequencer for one integrate-and-fire neuron: loads the membrane voltage, streams operand sets,
// waits out the neuron latency, strobes output_en, captures the results and counts spikes.
module neuron_seq_ctrl #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned NEURON_LAT = 1,
  parameter int unsigned OUT_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [CNT_W-1:0] num_pairs,
  input  logic [15:0]      init_vol,
  output logic             busy,
  output logic             done,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_act,
  input  logic [7:0]       s_wgt,
  input  logic [15:0]      s_diff,
  output logic [7:0]       n_activation,
  output logic [7:0]       n_weight,
  output logic [15:0]      n_input_mem_vol,
  output logic [15:0]      n_mem_vol_diff,
  output logic             n_load_en,
  output logic             n_arithm,
  output logic             n_input_valid,
  output logic             n_output_en,
  input  logic [15:0]      n_out_mem_vol,
  input  logic [15:0]      n_post_mem_vol_diff,
  input  logic             n_spike_out,
  output logic             res_valid,
  output logic [15:0]      res_mem_vol,
  output logic [15:0]      res_vol_diff,
  output logic             res_spike,
  output logic [15:0]      spike_cnt,
  input  logic             cnt_clr
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StFeed, StDrain, StOuten, StWaitout, StCapt
  } state_e;

  // Delay reload values; the num_pairs=0 path spends its first latency cycle in LOAD.
  localparam logic [3:0] DrainLd     = 4'(NEURON_LAT - 1);
  localparam logic [3:0] DrainLdZero = (NEURON_LAT >= 2) ? 4'(NEURON_LAT - 2) : 4'd0;
  localparam logic [3:0] WaitLd      = (OUT_LAT >= 2) ? 4'(OUT_LAT - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q;
  logic             mode_q;
  logic [CNT_W-1:0] np_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       dly_q;
  logic             accept;

  assign s_ready = (state_q == StFeed) && (cnt_q < np_q) && !abort;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      mode_q          <= 1'b0;
      np_q            <= '0;
      cnt_q           <= '0;
      dly_q           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      n_activation    <= '0;
      n_weight        <= '0;
      n_input_mem_vol <= '0;
      n_mem_vol_diff  <= '0;
      n_load_en       <= 1'b0;
      n_arithm        <= 1'b0;
      n_input_valid   <= 1'b0;
      n_output_en     <= 1'b0;
      res_valid       <= 1'b0;
      res_mem_vol     <= '0;
      res_vol_diff    <= '0;
      res_spike       <= 1'b0;
    end else begin
      n_load_en     <= 1'b0;
      n_input_valid <= 1'b0;
      n_output_en   <= 1'b0;
      res_valid     <= 1'b0;
      done          <= 1'b0;
      if (state_q != StIdle && abort) begin
        state_q  <= StIdle;
        busy     <= 1'b0;
        n_arithm <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            // done still high means this is the completion cycle; start waits one more cycle.
            if (start && !done) begin
              mode_q          <= mode;
              np_q            <= num_pairs;
              cnt_q           <= '0;
              n_input_mem_vol <= init_vol;
              n_load_en       <= 1'b1;
              n_arithm        <= mode;
              busy            <= 1'b1;
              state_q         <= StLoad;
            end
          end
          StLoad: begin
            if (np_q != '0) begin
              state_q <= StFeed;
            end else if (NEURON_LAT <= 1) begin
              state_q     <= StOuten;
              n_output_en <= 1'b1;
            end else begin
              state_q <= StDrain;
              dly_q   <= DrainLdZero;
            end
          end
          StFeed: begin
            if (accept) begin
              cnt_q          <= cnt_q + CntOne;
              n_input_valid  <= 1'b1;
              n_activation   <= s_act;
              n_weight       <= s_wgt;
              n_mem_vol_diff <= mode_q ? s_diff : 16'h0000;
              if (cnt_q + CntOne == np_q) begin
                state_q <= StDrain;
                dly_q   <= DrainLd;
              end
            end
          end
          StDrain: begin
            if (dly_q == 4'd0) begin
              state_q     <= StOuten;
              n_output_en <= 1'b1;
            end else begin
              dly_q <= dly_q - 4'd1;
            end
          end
          StOuten: begin
            if (OUT_LAT <= 1) begin
              state_q <= StCapt;
            end else begin
              state_q <= StWaitout;
              dly_q   <= WaitLd;
            end
          end
          StWaitout: begin
            if (dly_q == 4'd0) state_q <= StCapt;
            else dly_q <= dly_q - 4'd1;
          end
          StCapt: begin
            res_mem_vol  <= n_out_mem_vol;
            res_vol_diff <= n_post_mem_vol_diff;
            res_spike    <= n_spike_out;
            res_valid    <= 1'b1;
            done         <= 1'b1;
            busy         <= 1'b0;
            n_arithm     <= 1'b0;
            state_q      <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_cnt <= '0;
    end else if (cnt_clr) begin
      spike_cnt <= '0;
    end else if (state_q == StCapt && !abort && n_spike_out && spike_cnt != 16'hFFFF) begin
      spike_cnt <= spike_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Scoreboard bench for neuron_seq_ctrl: stimulus pushes expected neuron-side events, a negedge
// monitor pops and compares them, and a random neuron model supplies the captured values.
module tb_neuron_seq_ctrl;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned NEURON_LAT = 1;
  localparam int unsigned OUT_LAT    = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             mode = 1'b0;
  logic [CNT_W-1:0] num_pairs = '0;
  logic [15:0]      init_vol = '0;
  logic             busy, done, s_ready;
  logic             s_valid = 1'b0;
  logic [7:0]       s_act = '0;
  logic [7:0]       s_wgt = '0;
  logic [15:0]      s_diff = '0;
  logic [7:0]       n_activation, n_weight;
  logic [15:0]      n_input_mem_vol, n_mem_vol_diff;
  logic             n_load_en, n_arithm, n_input_valid, n_output_en;
  logic [15:0]      n_out_mem_vol = '0;
  logic [15:0]      n_post_mem_vol_diff = '0;
  logic             n_spike_out = 1'b0;
  logic             res_valid, res_spike;
  logic [15:0]      res_mem_vol, res_vol_diff, spike_cnt;
  logic             cnt_clr = 1'b0;

  always #5 clk = ~clk;

  neuron_seq_ctrl #(
    .CNT_W(CNT_W), .NEURON_LAT(NEURON_LAT), .OUT_LAT(OUT_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .num_pairs(num_pairs), .init_vol(init_vol), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_act(s_act), .s_wgt(s_wgt), .s_diff(s_diff),
    .n_activation(n_activation), .n_weight(n_weight), .n_input_mem_vol(n_input_mem_vol),
    .n_mem_vol_diff(n_mem_vol_diff), .n_load_en(n_load_en), .n_arithm(n_arithm),
    .n_input_valid(n_input_valid), .n_output_en(n_output_en),
    .n_out_mem_vol(n_out_mem_vol), .n_post_mem_vol_diff(n_post_mem_vol_diff),
    .n_spike_out(n_spike_out), .res_valid(res_valid), .res_mem_vol(res_mem_vol),
    .res_vol_diff(res_vol_diff), .res_spike(res_spike), .spike_cnt(spike_cnt),
    .cnt_clr(cnt_clr)
  );

  typedef struct packed {logic [15:0] iv; logic m; logic [31:0] cyc;} load_t;
  typedef struct packed {logic [7:0] a; logic [7:0] w; logic [15:0] d; logic [31:0] cyc;} in_t;

  load_t load_q[$];
  in_t   in_q[$];
  logic  run_q[$];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          runs_started = 0;
  int unsigned cyc = 0;
  int unsigned last_cyc = 0;
  int unsigned oe_cyc = 0;
  logic        oe_pend = 1'b0;
  logic        cur_mode = 1'b0;
  logic        run_mode = 1'b0;
  logic        spike_force = 1'b0;
  logic        sc_chk = 1'b0;
  logic [15:0] sc_model = '0;
  logic [15:0] res_mv_m = '0;
  logic [15:0] res_vd_m = '0;
  logic        res_sp_m = 1'b0;
  logic [15:0] hist_mv[256];
  logic [15:0] hist_vd[256];
  logic        hist_sp[256];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Neuron stand-in: fresh random outputs every cycle, remembered per cycle for the capture check.
  initial forever begin
    @(posedge clk);
    #1;
    n_out_mem_vol       = 16'($urandom);
    n_post_mem_vol_diff = 16'($urandom);
    n_spike_out         = spike_force ? 1'b1 : 1'($urandom_range(0, 1));
    hist_mv[8'(cyc)]    = n_out_mem_vol;
    hist_vd[8'(cyc)]    = n_post_mem_vol_diff;
    hist_sp[8'(cyc)]    = n_spike_out;
  end

  // Monitor
  initial forever begin
    load_t ld;
    in_t   iv;
    @(negedge clk);
    if (rst_n) begin
      if (n_load_en) begin
        chk("load expected", 32'(load_q.size() != 0), 32'd1);
        if (load_q.size() != 0) begin
          ld = load_q.pop_front();
          chk("load cycle", cyc, ld.cyc);
          chk("init_vol", 32'(n_input_mem_vol), 32'(ld.iv));
          chk("busy at load", 32'(busy), 32'd1);
          cur_mode = ld.m;
        end
        last_cyc = cyc;
      end
      if (busy) chk("n_arithm", 32'(n_arithm), 32'(cur_mode));
      if (n_input_valid) begin
        chk("input_valid expected", 32'(in_q.size() != 0), 32'd1);
        if (in_q.size() != 0) begin
          iv = in_q.pop_front();
          chk("input_valid cycle", cyc, iv.cyc);
          chk("activation", 32'(n_activation), 32'(iv.a));
          chk("weight", 32'(n_weight), 32'(iv.w));
          chk("mem_vol_diff", 32'(n_mem_vol_diff), 32'(iv.d));
        end
        last_cyc = cyc;
      end
      if (n_output_en) begin
        chk("output_en expected", 32'(run_q.size() != 0 && !oe_pend), 32'd1);
        chk("output_en latency", cyc - last_cyc, NEURON_LAT);
        oe_pend = 1'b1;
        oe_cyc  = cyc;
      end
      if (done) begin
        chk("done expected", 32'(run_q.size() != 0 && oe_pend), 32'd1);
        if (run_q.size() != 0) void'(run_q.pop_front());
        chk("done latency", cyc - oe_cyc, OUT_LAT + 1);
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("busy at done", 32'(busy), 32'd0);
        chk("res_mem_vol", 32'(res_mem_vol), 32'(res_mv_m));
        chk("res_vol_diff", 32'(res_vol_diff), 32'(res_vd_m));
        chk("res_spike", 32'(res_spike), 32'(res_sp_m));
        chk("spike_cnt at done", 32'(spike_cnt), 32'(sc_model));
        oe_pend = 1'b0;
        done_cnt++;
      end else if (res_valid) begin
        chk("res_valid with done", 32'(done), 32'd1);
      end
      if (sc_chk) begin
        chk("spike_cnt after clear", 32'(spike_cnt), 32'(sc_model));
        sc_chk = 1'b0;
      end
      // Model of what the coming edge does to the result registers and spike counter.
      if (busy && abort) begin
        oe_pend = 1'b0;
      end else if (oe_pend && cyc == oe_cyc + OUT_LAT) begin
        res_mv_m = hist_mv[8'(cyc)];
        res_vd_m = hist_vd[8'(cyc)];
        res_sp_m = hist_sp[8'(cyc)];
        if (res_sp_m && sc_model != 16'hFFFF) sc_model = sc_model + 16'd1;
      end
      if (cnt_clr) begin
        sc_model = '0;
        sc_chk   = 1'b1;
      end
    end
  end

  task automatic do_start(input logic m, input logic [CNT_W-1:0] np, input logic [15:0] iv);
    load_t ld;
    start = 1'b1; mode = m; num_pairs = np; init_vol = iv;
    ld.iv = iv; ld.m = m; ld.cyc = cyc + 1;
    load_q.push_back(ld);
    run_q.push_back(m);
    run_mode = m;
    runs_started++;
    @(posedge clk); #1;
    // Scramble the run fields to show they were latched.
    start = 1'b0; mode = 1'($urandom); num_pairs = CNT_W'($urandom); init_vol = 16'($urandom);
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] w, input logic [15:0] d);
    in_t e;
    int  t = 0;
    s_valid = 1'b1; s_act = a; s_wgt = w; s_diff = d;
    @(negedge clk);
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("operand accepted", 32'(s_ready), 32'd1);
    if (s_ready) begin
      e.a = a; e.w = w; e.d = run_mode ? d : 16'h0000; e.cyc = cyc + 1;
      in_q.push_back(e);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt < runs_started && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("run completes", 32'(done_cnt >= runs_started), 32'd1);
    runs_started = done_cnt;
    #1;
  endtask

  task automatic wait_oe();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!n_output_en && t < 200);
    chk("output_en seen", 32'(n_output_en), 32'd1);
  endtask

  initial begin
    int          rc;
    int          base;
    logic        m;
    int unsigned np;
    int unsigned g;

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset s_ready", 32'(s_ready), 32'd0);
    chk("reset strobes", 32'({n_load_en, n_input_valid, n_output_en, n_arithm}), 32'd0);
    chk("reset res", 32'({res_valid, res_spike, res_mem_vol}), 32'd0);
    chk("reset spike_cnt", 32'(spike_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MAC run, back-to-back operands, then a start issued in the done cycle.
    do_start(1'b0, CNT_W'(4), 16'd63);
    offer(8'd5, 8'd8, 16'h1234);
    offer(8'd9, 8'(-4), 16'h5555);
    offer(8'(-7), 8'd10, 16'h7777);
    offer(8'(-5), 8'(-3), 16'h0f0f);
    wait_oe();
    repeat (OUT_LAT + 1) @(posedge clk);
    #1;
    start = 1'b1; init_vol = 16'($urandom);
    @(negedge clk);
    chk("done-cycle probe", 32'(done), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start in done cycle ignored", 32'(busy), 32'd0);
    @(posedge clk); #1;
    runs_started = done_cnt;

    // Diff-accumulate run with a one-cycle operand gap.
    do_start(1'b1, CNT_W'(2), 16'($urandom));
    offer(8'd40, 8'd1, 16'd43);
    @(posedge clk); #1;
    offer(8'(-4), 8'(-3), 16'd120);
    wait_done();

    // Zero operand sets: s_ready must never rise.
    do_start(1'b0, CNT_W'(0), 16'(-5));
    s_valid = 1'b1;
    rc = 0;
    for (int t = 0; t < 50 && done_cnt < runs_started; t++) begin
      @(negedge clk);
      if (s_ready) rc++;
    end
    chk("np0 s_ready cycles", 32'(rc), 32'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_done();

    // Abort in the second FEED cycle.
    do_start(1'b0, CNT_W'(4), 16'($urandom));
    offer(8'($urandom), 8'($urandom), 16'($urandom));
    s_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("s_ready in abort cycle", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0;
    void'(run_q.pop_back());
    runs_started--;
    @(negedge clk);
    chk("busy after abort", 32'(busy), 32'd0);
    chk("strobes after abort", 32'({n_load_en, n_input_valid, n_output_en}), 32'd0);
    base = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("no done after abort", 32'(done_cnt), 32'(base));
    chk("res held after abort", 32'(res_mem_vol), 32'(res_mv_m));
    do_start(1'b1, CNT_W'(1), 16'($urandom));
    offer(8'($urandom), 8'($urandom), 16'($urandom));
    wait_done();

    // Asynchronous reset while draining.
    do_start(1'b1, CNT_W'(2), 16'($urandom));
    offer(8'($urandom), 8'($urandom), 16'($urandom));
    offer(8'($urandom), 8'($urandom), 16'($urandom));
    rst_n = 1'b0;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst strobes", 32'({n_input_valid, n_load_en, n_output_en, n_arithm}), 32'd0);
    chk("async rst res", 32'({res_valid, res_mem_vol, res_vol_diff}), 32'd0);
    chk("async rst spike_cnt", 32'(spike_cnt), 32'd0);
    load_q.delete(); in_q.delete(); run_q.delete();
    oe_pend = 1'b0; sc_model = '0; res_mv_m = '0; res_vd_m = '0; res_sp_m = 1'b0;
    base = done_cnt;
    runs_started = done_cnt;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no done after reset", 32'(done_cnt), 32'(base));
    chk("idle after reset", 32'(busy), 32'd0);

    // Spike counting, clear colliding with a capture, and saturation.
    spike_force = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      do_start(1'b0, CNT_W'(1), 16'($urandom));
      offer(8'($urandom), 8'($urandom), 16'($urandom));
      wait_done();
      chk("spike_cnt run", 32'(spike_cnt), 32'(k));
    end
    do_start(1'b0, CNT_W'(1), 16'($urandom));
    offer(8'($urandom), 8'($urandom), 16'($urandom));
    wait_oe();
    repeat (OUT_LAT) @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(posedge clk); #1;
    runs_started = done_cnt;
    chk("clear beats capture", 32'(spike_cnt), 32'd0);
    force dut.spike_cnt = 16'hFFFF;
    sc_model = 16'hFFFF;
    @(posedge clk); #1;
    release dut.spike_cnt;
    do_start(1'b1, CNT_W'(1), 16'($urandom));
    offer(8'($urandom), 8'($urandom), 16'($urandom));
    wait_done();
    chk("spike_cnt saturates", 32'(spike_cnt), 32'hFFFF);
    spike_force = 1'b0;

    // Random runs with gaps and stray start pulses while busy.
    for (int r = 0; r < 30; r++) begin
      m  = 1'($urandom);
      np = $urandom_range(0, 6);
      do_start(m, CNT_W'(np), 16'($urandom));
      for (int i = 0; i < int'(np); i++) begin
        g = $urandom_range(0, 2);
        for (int j = 0; j < int'(g); j++) begin
          if ($urandom_range(0, 3) == 0) begin
            start = 1'b1; mode = 1'($urandom); init_vol = 16'($urandom);
          end
          @(posedge clk); #1;
          start = 1'b0;
        end
        offer(8'($urandom), 8'($urandom), 16'($urandom));
      end
      wait_done();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("load queue drained", 32'(load_q.size()), 32'd0);
    chk("input queue drained", 32'(in_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
